boss_ctrl: RTL and testbench
============================

# boss_ctrl

Parametrised boss-motion controller for the shooter's final stage. It replaces the fixed three-phase boss mover with:
- a registered state machine with an entry animation;
- bouncing horizontal patrol;
- monotonic HP-driven phase escalation;
- a timed death sequence.

It sits between the enemy/HP bookkeeping logic and the VGA sprite renderer, and produces the boss position, visibility and phase status at the clk22 game-tick rate.

## Interface
Parameters:
- W, 10, coordinate width of bossx/bossy
- HPW, 10, width of bosshp
- N_ENEMY, 4, number of regular-enemy alive flags
- HP_MAX, 450, maximum HP at which the boss may spawn
- TH1, 300, phase-1/phase-2 HP boundary (phase 1 when hp > TH1)
- TH2, 150, phase-2/phase-3 HP boundary (phase 2 when TH2 < hp <= TH1)
- X_MIN, 50, left patrol limit
- X_MAX, 400, right patrol limit
- Y_HOME, 75, spawn and phase-1 y
- Y_LOW, 150, phase-2/3 descent target y
- SPD_X, 3, horizontal step per tick in phases 1–2 (phase 3 uses 2*SPD_X)
- SPD_Y, 1, vertical descent step per tick
- DEATH_TICKS, 32, cycles spent in DYING

Ports:
- clk22  in  1  game-tick clock
- rst  in  1  reset; synchronous, active-high
- enma  in  N_ENEMY  alive flags of regular enemies; boss may spawn only when all are 0
- bosshp  in  HPW  current boss HP
- bossx  out  W  boss x position
- bossy  out  W  boss y position
- boss  out  1  boss visible/active
- phase  out  2  0 = not fighting, 1/2/3 = combat phase
- dying  out  1  high during the death sequence
- defeated  out  1  high from DONE until rst

## Operation
- States: IDLE, ENTER, P1, P2, P3, DYING, DONE. All outputs are registered and decoded from state/position registers.
- Reset values: state IDLE, bossx=0, bossy=Y_HOME, boss=0, phase=0, dying=0, defeated=0, dir=right, death counter=0.
- IDLE:
  - Outputs hold reset values.
  - Go to ENTER when enma==0, 0<bosshp and bosshp<=HP_MAX. Otherwise stay.
- ENTER:
  - boss=1, phase=0, bossy=Y_HOME.
  - bossx <= min(bossx+SPD_X, X_MIN) each tick.
  - When bossx==X_MIN, go to the phase selected by bosshp; dir=right.
- Phase selection from bosshp:
  - bosshp > TH1 gives P1.
  - bosshp > TH2 gives P2.
  - bosshp > 0 gives P3.
  - bosshp == 0 gives DYING.
- Escalation is monotonic. The state moves only to a higher phase; phases may be skipped (P1 to P3 directly). HP rising never lowers the phase.
- Once the state has left IDLE, enma is ignored.
- Patrol in P1/P2/P3, with step S = SPD_X in P1/P2 and 2*SPD_X in P3:
  - Moving right: if bossx+S >= X_MAX, then bossx <= X_MAX and dir <= left. Otherwise bossx <= bossx+S.
  - Moving left: if bossx-S <= X_MIN, then bossx <= X_MIN and dir <= right. Otherwise bossx <= bossx-S.
  - All sums and differences are computed in W+1 bits, so no wrap-around is permitted.
- P1: bossy=Y_HOME.
- P2/P3: bossy <= min(bossy+SPD_Y, Y_LOW). The patrol continues while descending.
- Any of ENTER, P1, P2, P3 with bosshp==0 goes to DYING:
  - bossx/bossy freeze at their current values.
  - boss=1, dying=1, phase=0.
  - The counter loads DEATH_TICKS-1 and decrements each tick; on 0, go to DONE.
- DONE: boss=0, bossx=0, bossy=0, dying=0, defeated=1. Held until rst; bosshp and enma are ignored.
- Simultaneous events have the following priority: rst, then hp==0, then phase escalation, then movement.
  - On a phase change, that tick's move uses the new phase's step.

## Timing
- Every input-driven state change appears at the next clk22 edge (1-cycle latency). No combinational path runs from input to output.
- boss rises on the same edge that the state enters ENTER, with bossx=0 in that cycle. The first movement occurs on the following edge.
- DYING lasts exactly DEATH_TICKS cycles. defeated rises on the edge after the last DYING cycle.
- rst asserted in any state, including mid-DYING, returns all outputs to reset values at the next edge.

## Test plan
- Spawn gating:
  - rst; then enma=4'b0001, bosshp=450 for 10 ticks gives boss=0, bossx=0, bossy=75.
  - Then enma=0 gives boss=1, bossx=0 next edge.
  - bossx then steps 3,6,…,48,50, reaching 50 after 17 moves; phase=1 on the following edge.
  - bosshp=451 or 0 with enma=0 keeps IDLE.
- Patrol bounce: in P1 with bossx=398, dir right gives bossx=400 and dir left, then 397, 394…; at bossx=52 moving left gives 50, then 53.
- Phase 2:
  - bosshp drops 450 to 250 gives phase=2 next edge.
  - bossy 75 to 150 in 75 ticks, then holds 150 while x keeps patrolling at step 3.
  - bosshp raised back to 400 keeps phase=2.
- Skip to phase 3: in P1, bosshp 450 to 100 gives phase=3, x step 6, y descends to 150.
- Death:
  - In P3 at (x=200, y=150), bosshp=0 gives dying=1, boss=1, position frozen for exactly 32 cycles.
  - Then boss=0, x=y=0, defeated=1.
  - defeated stays 1 despite enma=0, bosshp=300.
- Reset mid-sequence: rst at DYING cycle 10 gives IDLE, boss=0, bossx=0, bossy=75, dying=0, defeated=0 next edge.

Source files
------------

// File: rtl/boss_ctrl.sv
// Final-stage boss motion controller: spawn gating, entry slide, bouncing patrol,
// monotonic HP-driven phase escalation and a timed death sequence.
module boss_ctrl #(
  parameter int W           = 10,
  parameter int HPW         = 10,
  parameter int N_ENEMY     = 4,
  parameter int HP_MAX      = 450,
  parameter int TH1         = 300,
  parameter int TH2         = 150,
  parameter int X_MIN       = 50,
  parameter int X_MAX       = 400,
  parameter int Y_HOME      = 75,
  parameter int Y_LOW       = 150,
  parameter int SPD_X       = 3,
  parameter int SPD_Y       = 1,
  parameter int DEATH_TICKS = 32
) (
  input  logic               clk22,
  input  logic               rst,
  input  logic [N_ENEMY-1:0] enma,
  input  logic [HPW-1:0]     bosshp,
  output logic [W-1:0]       bossx,
  output logic [W-1:0]       bossy,
  output logic               boss,
  output logic [1:0]         phase,
  output logic               dying,
  output logic               defeated
);

  // state   | meaning
  // IDLE    | waiting for the regular wave to clear
  // ENTER   | sliding in from x=0 to X_MIN
  // P1..P3  | combat phases, patrol + descent in P2/P3
  // DYING   | frozen, counting down the death animation
  // DONE    | boss gone, defeated held until reset
  typedef enum logic [2:0] {
    S_IDLE, S_ENTER, S_P1, S_P2, S_P3, S_DYING, S_DONE
  } state_t;

  localparam int CW = $clog2(DEATH_TICKS + 1);
  localparam int WE = W + 1;

  localparam logic [WE-1:0]  XMIN_E  = WE'(X_MIN);
  localparam logic [WE-1:0]  XMAX_E  = WE'(X_MAX);
  localparam logic [WE-1:0]  YLOW_E  = WE'(Y_LOW);
  localparam logic [W-1:0]   XMIN_V  = W'(X_MIN);
  localparam logic [W-1:0]   XMAX_V  = W'(X_MAX);
  localparam logic [W-1:0]   YHOME_V = W'(Y_HOME);
  localparam logic [W-1:0]   YLOW_V  = W'(Y_LOW);
  localparam logic [HPW-1:0] HPMAX_V = HPW'(HP_MAX);
  localparam logic [HPW-1:0] TH1_V   = HPW'(TH1);
  localparam logic [HPW-1:0] TH2_V   = HPW'(TH2);

  state_t          state_q;
  logic [W-1:0]    bossx_q, bossy_q;
  logic            dir_q;
  logic [CW-1:0]   cnt_q;
  logic            boss_q, dying_q, defeated_q;
  logic [1:0]      phase_q;

  logic            hp_zero, spawn_ok;
  logic [1:0]      hp_rank, cur_rank, new_rank;
  state_t          hp_state, new_state;
  logic [WE-1:0]   x_ext, step_e, xsum, esum, ysum;
  logic [W-1:0]    px_d, ex_d, py_d;
  logic            pdir_d;

  function automatic state_t rank_to_state(input logic [1:0] r);
    case (r)
      2'd1:    return S_P1;
      2'd2:    return S_P2;
      default: return S_P3;
    endcase
  endfunction

  always_comb begin
    hp_zero  = (bosshp == '0);
    spawn_ok = (enma == '0) && !hp_zero && (bosshp <= HPMAX_V);

    if (bosshp > TH1_V)      hp_rank = 2'd1;
    else if (bosshp > TH2_V) hp_rank = 2'd2;
    else if (!hp_zero)       hp_rank = 2'd3;
    else                     hp_rank = 2'd0;

    case (state_q)
      S_P1:    cur_rank = 2'd1;
      S_P2:    cur_rank = 2'd2;
      S_P3:    cur_rank = 2'd3;
      default: cur_rank = 2'd0;
    endcase

    // HP only ever pushes the phase upward
    new_rank  = (hp_rank > cur_rank) ? hp_rank : cur_rank;
    new_state = rank_to_state(new_rank);
    hp_state  = rank_to_state(hp_rank);

    // all patrol arithmetic is one bit wider so nothing wraps
    x_ext  = {1'b0, bossx_q};
    step_e = (new_rank == 2'd3) ? WE'(2 * SPD_X) : WE'(SPD_X);
    xsum   = x_ext + step_e;
    px_d   = bossx_q;
    pdir_d = dir_q;
    if (!dir_q) begin
      if (xsum >= XMAX_E) begin
        px_d   = XMAX_V;
        pdir_d = 1'b1;
      end else begin
        px_d = xsum[W-1:0];
      end
    end else begin
      if (x_ext <= XMIN_E + step_e) begin
        px_d   = XMIN_V;
        pdir_d = 1'b0;
      end else begin
        px_d = W'(x_ext - step_e);
      end
    end

    esum = x_ext + WE'(SPD_X);
    ex_d = (esum >= XMIN_E) ? XMIN_V : esum[W-1:0];

    ysum = {1'b0, bossy_q} + WE'(SPD_Y);
    if (new_rank == 2'd1)     py_d = YHOME_V;
    else if (ysum >= YLOW_E)  py_d = YLOW_V;
    else                      py_d = ysum[W-1:0];
  end

  always_ff @(posedge clk22) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bossx_q    <= '0;
      bossy_q    <= YHOME_V;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
      boss_q     <= 1'b0;
      phase_q    <= 2'd0;
      dying_q    <= 1'b0;
      defeated_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (spawn_ok) begin
            state_q <= S_ENTER;
            boss_q  <= 1'b1;
          end
        end
        S_ENTER, S_P1, S_P2, S_P3: begin
          if (hp_zero) begin
            state_q <= S_DYING;
            dying_q <= 1'b1;
            phase_q <= 2'd0;
            cnt_q   <= CW'(DEATH_TICKS - 1);
          end else if (state_q == S_ENTER) begin
            if (bossx_q == XMIN_V) begin
              state_q <= hp_state;
              phase_q <= hp_rank;
              dir_q   <= 1'b0;
            end else begin
              bossx_q <= ex_d;
            end
          end else begin
            state_q <= new_state;
            phase_q <= new_rank;
            bossx_q <= px_d;
            dir_q   <= pdir_d;
            bossy_q <= py_d;
          end
        end
        S_DYING: begin
          if (cnt_q == '0) begin
            state_q    <= S_DONE;
            boss_q     <= 1'b0;
            bossx_q    <= '0;
            bossy_q    <= '0;
            dying_q    <= 1'b0;
            defeated_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bossx    = bossx_q;
  assign bossy    = bossy_q;
  assign boss     = boss_q;
  assign phase    = phase_q;
  assign dying    = dying_q;
  assign defeated = defeated_q;

endmodule

// File: tb/tb_boss_ctrl.sv
// Directed bench for boss_ctrl: spawn gating, entry, patrol bounce, phase
// escalation, death timing and reset during the death sequence.
module tb_boss_ctrl;

  logic       clk22 = 1'b0;
  logic       rst;
  logic [3:0] enma;
  logic [9:0] bosshp;
  logic [9:0] bossx, bossy;
  logic       boss, dying, defeated;
  logic [1:0] phase;

  int n_checks = 0;
  int n_errors = 0;

  boss_ctrl dut (
    .clk22    (clk22),
    .rst      (rst),
    .enma     (enma),
    .bosshp   (bosshp),
    .bossx    (bossx),
    .bossy    (bossy),
    .boss     (boss),
    .phase    (phase),
    .dying    (dying),
    .defeated (defeated)
  );

  always #5 clk22 = ~clk22;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance n rising edges, then park on the falling edge for sampling/driving
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk22);
      @(negedge clk22);
    end
  endtask

  task automatic chk_pos(input string tag, input int x, input int y);
    chk({tag, ".x"}, 32'(bossx), x);
    chk({tag, ".y"}, 32'(bossy), y);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_pos(tag, 0, 75);
    chk({tag, ".boss"},     32'(boss),     0);
    chk({tag, ".phase"},    32'(phase),    0);
    chk({tag, ".dying"},    32'(dying),    0);
    chk({tag, ".defeated"}, 32'(defeated), 0);
  endtask

  // release reset with the wave clear and full HP, then walk ENTER to P1
  task automatic spawn_to_p1();
    rst = 1'b0; enma = 4'b0000; bosshp = 10'd450;
    tick(1);
    chk("spawn.boss", 32'(boss), 1);
    chk("spawn.x", 32'(bossx), 0);
    enma = 4'b1111;
    for (int k = 1; k <= 17; k++) begin
      tick(1);
      chk("enter.x", 32'(bossx), (3 * k < 50) ? 3 * k : 50);
      chk("enter.phase", 32'(phase), 0);
    end
    tick(1);
    chk("p1.phase", 32'(phase), 1);
    chk_pos("p1.start", 50, 75);
  endtask

  initial begin
    rst = 1'b1; enma = 4'b0001; bosshp = 10'd450;
    @(negedge clk22);
    tick(2);
    chk_reset_vals("reset");

    rst = 1'b0;
    tick(10);
    chk("gate.enma.boss", 32'(boss), 0);
    chk_pos("gate.enma", 0, 75);

    enma = 4'b0000; bosshp = 10'd451;
    tick(3);
    chk("gate.hp451.boss", 32'(boss), 0);
    bosshp = 10'd0;
    tick(3);
    chk("gate.hp0.boss", 32'(boss), 0);

    spawn_to_p1();

    // P1 bounce off both walls
    tick(116);
    chk_pos("p1.pre_right", 398, 75);
    tick(1);
    chk("p1.right_wall.x", 32'(bossx), 400);
    tick(1);
    chk("p1.left1.x", 32'(bossx), 397);
    tick(1);
    chk("p1.left2.x", 32'(bossx), 394);
    tick(114);
    chk("p1.pre_left.x", 32'(bossx), 52);
    tick(1);
    chk("p1.left_wall.x", 32'(bossx), 50);
    tick(1);
    chk("p1.rebound.x", 32'(bossx), 53);

    // P2 descent; move on the escalation tick already descends
    bosshp = 10'd250;
    tick(1);
    chk("p2.phase", 32'(phase), 2);
    chk_pos("p2.first", 56, 76);
    tick(74);
    chk_pos("p2.floor", 278, 150);
    tick(1);
    chk_pos("p2.hold", 281, 150);
    bosshp = 10'd400;
    tick(3);
    chk("p2.no_deescalate", 32'(phase), 2);
    chk("p2.step3.x", 32'(bossx), 290);

    // reset mid-P2, then skip P1 -> P3
    rst = 1'b1;
    tick(1);
    chk_reset_vals("reset.p2");
    spawn_to_p1();
    bosshp = 10'd100;
    tick(1);
    chk("p3.phase", 32'(phase), 3);
    chk_pos("p3.first", 56, 76);
    tick(58);
    chk_pos("p3.right_wall", 400, 134);
    tick(16);
    chk_pos("p3.floor", 304, 150);
    tick(68);
    chk_pos("p3.at200", 200, 150);

    // death: 32 frozen cycles, then DONE
    bosshp = 10'd0;
    for (int c = 0; c < 32; c++) begin
      tick(1);
      chk("die.dying", 32'(dying), 1);
      chk("die.boss", 32'(boss), 1);
      chk("die.phase", 32'(phase), 0);
      chk_pos("die.freeze", 200, 150);
    end
    tick(1);
    chk("done.defeated", 32'(defeated), 1);
    chk("done.boss", 32'(boss), 0);
    chk("done.dying", 32'(dying), 0);
    chk_pos("done", 0, 0);
    enma = 4'b0000; bosshp = 10'd300;
    tick(5);
    chk("done.hold.defeated", 32'(defeated), 1);
    chk("done.hold.boss", 32'(boss), 0);

    // reset at DYING cycle 10 (death entered from ENTER)
    rst = 1'b1;
    tick(1);
    rst = 1'b0; enma = 4'b0000; bosshp = 10'd450;
    tick(1);
    chk("respawn.boss", 32'(boss), 1);
    tick(2);
    chk("respawn.x", 32'(bossx), 6);
    bosshp = 10'd0;
    tick(1);
    chk("enter_die.dying", 32'(dying), 1);
    chk_pos("enter_die", 6, 75);
    tick(9);
    chk("enter_die.c10", 32'(dying), 1);
    rst = 1'b1;
    tick(1);
    chk_reset_vals("reset.dying");
    rst = 1'b0;
    tick(2);
    chk("idle.hp0.boss", 32'(boss), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
